// File: rtl/parity_arb_pkg.sv
// -----------------------------------------------------------------------------
// parity_arb_pkg
//
// Purpose:
//   Shared definitions for the parity_share_arb front end and for other parity
//   users in the verification environment.
//
// Contents:
//   state_t      FSM state encoding (IDLE, RESP)
//   PAR_MAXW     widest operand the shared parity function accepts
//   id_width()   width of a requester index for a given requester count
//   xor_reduce() XOR of all bits of an operand (even parity bit)
// -----------------------------------------------------------------------------
package parity_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int PAR_MAXW = 32;

  // Index width for n requesters; never less than one bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Callers zero-extend narrower operands; zero bits do not change the XOR.
  function automatic logic xor_reduce(input logic [PAR_MAXW-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/xor_reduce.sv
// -----------------------------------------------------------------------------
// xor_reduce
//
// Purpose:
//   Purely combinational parity datapath shared by all requesters of
//   parity_share_arb. The output is the XOR of every input bit.
//
// Parameters:
//   WIDTH     operand width in bits (1..32)
//
// Ports:
//   i_data    input  [WIDTH-1:0]  operand
//   o_parity  output              XOR of all bits of i_data
// -----------------------------------------------------------------------------
module xor_reduce #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  logic [parity_arb_pkg::PAR_MAXW-1:0] w_data_ext;

  assign w_data_ext = parity_arb_pkg::PAR_MAXW'(i_data);
  assign o_parity   = parity_arb_pkg::xor_reduce(w_data_ext);

endmodule

// File: rtl/parity_share_arb.sv
// -----------------------------------------------------------------------------
// parity_share_arb
//
// Purpose:
//   Arbitrated front end that lets NREQ requesters share one xor_reduce
//   datapath. A granted operand is captured together with its parity and the
//   requester index, and is presented as one registered response on a single
//   valid/ready output channel. op_cnt counts completed response handshakes.
//
// Configuration macro:
//   RR_ARB_EN  defined   : round-robin arbitration; search starts at ptr+1
//              undefined : fixed priority, lowest index wins; no pointer
//
// Parameters:
//   NREQ   number of requesters (2..16)
//   WIDTH  operand width (1..32)
//   CNTW   width of op_cnt
//
// Ports:
//   clk         input               clock, rising edge
//   rst         input               asynchronous active-high reset
//   req_valid   input  [NREQ-1:0]   per-requester operand valid
//   req_data    input  [NREQ*WIDTH-1:0] operand i at [i*WIDTH +: WIDTH]
//   req_ready   output [NREQ-1:0]   one-hot grant (combinational)
//   rsp_valid   output              response valid
//   rsp_ready   input               response accepted
//   rsp_id      output [IDW-1:0]    index of granted requester
//   rsp_data    output [WIDTH-1:0]  captured operand
//   rsp_parity  output              XOR of rsp_data
//   op_cnt      output [CNTW-1:0]   completed response handshakes (wraps)
//   busy        output              rsp_valid or any req_valid
//
// FSM:
//   IDLE | no response held, accept any request
//   RESP | response held; accept a new request only when rsp_ready is high
// -----------------------------------------------------------------------------
module parity_share_arb
  import parity_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3,
  parameter int CNTW  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*WIDTH-1:0]       req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [id_width(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]            rsp_data,
  output logic                        rsp_parity,
  output logic [CNTW-1:0]             op_cnt,
  output logic                        busy
);

  localparam int IDW = id_width(NREQ);

  state_t           r_state;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_parity;
  logic [CNTW-1:0]  r_op_cnt;
`ifdef RR_ARB_EN
  logic [IDW-1:0]   r_ptr;
`endif

  logic             w_accept;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic             w_grant;
  logic [WIDTH-1:0] w_win_data;
  logic             w_win_parity;

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  always_comb begin : arb
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
`ifdef RR_ARB_EN
    for (int k = 0; k < NREQ; k++) begin
      // ptr <= NREQ-1 and k <= NREQ-1, so a single subtraction wraps it;
      // the explicit compare keeps non-power-of-2 NREQ correct.
      idx = int'(r_ptr) + 1 + k;
      if (idx > NREQ - 1) begin
        idx = idx - NREQ;
      end
      if (!w_found && req_valid[IDW'(idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = k;
      if (!w_found && req_valid[IDW'(idx)]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
`endif
  end

  assign w_accept = (r_state == IDLE) | ((r_state == RESP) & rsp_ready);
  // rst gates the grant so no requester sees an accept while in reset.
  assign w_grant  = w_accept & w_found & ~rst;

  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready = NREQ'(1) << w_win;
    end
  end

  assign w_win_data = req_data[int'(w_win)*WIDTH +: WIDTH];

  xor_reduce #(
    .WIDTH (WIDTH)
  ) u_xor_reduce (
    .i_data   (w_win_data),
    .o_parity (w_win_parity)
  );

  // ---------------------------------------------------------------------------
  // FSM, response registers and handshake counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
      r_rsp_parity <= 1'b0;
      r_op_cnt     <= '0;
`ifdef RR_ARB_EN
      r_ptr        <= IDW'(NREQ - 1);
`endif
    end else begin
      // Counts the response leaving this cycle, even if a new one loads now.
      if (r_rsp_valid && rsp_ready) begin
        r_op_cnt <= r_op_cnt + CNTW'(1);
      end

      if (w_grant) begin
        r_state      <= RESP;
        r_rsp_valid  <= 1'b1;
        r_rsp_id     <= w_win;
        r_rsp_data   <= w_win_data;
        r_rsp_parity <= w_win_parity;
`ifdef RR_ARB_EN
        r_ptr        <= w_win;
`endif
      end else if ((r_state == RESP) && rsp_ready) begin
        r_state     <= IDLE;
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_parity = r_rsp_parity;
  assign op_cnt     = r_op_cnt;
  assign busy       = r_rsp_valid | (|req_valid);

endmodule

// File: tb/tb_parity_share_arb.sv
// Directed bench for parity_share_arb (NREQ=4, WIDTH=3, CNTW=4).
module tb_parity_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [11:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_data;
  logic        rsp_parity;
  logic [3:0]  op_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [2:0] sl [4];
  int         exp_id;
  int         nxt_id;

  parity_share_arb #(
    .NREQ  (4),
    .WIDTH (3),
    .CNTW  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_parity (rsp_parity),
    .op_cnt     (op_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sl[0] = 3'b001; sl[1] = 3'b010; sl[2] = 3'b011; sl[3] = 3'b100;

    // Reset state; requests during reset are never granted
    rst = 1'b1; req_valid = 4'hF; req_data = '0; rsp_ready = 1'b0;
    #2;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_parity", 32'(rsp_parity), 0);
    check("rst_op_cnt", 32'(op_cnt), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    tick();
    rst = 1'b0; req_valid = 4'h0;

    // Requester 0, data 101, rsp_ready=1
    req_valid = 4'b0001; req_data = 12'b000_000_000_101; rsp_ready = 1'b1;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'b0001);
    check("t1_busy", 32'(busy), 1);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rsp_id", 32'(rsp_id), 0);
    check("t1_rsp_data", 32'(rsp_data), 32'b101);
    check("t1_rsp_parity", 32'(rsp_parity), 0);
    check("t1_cnt_before_hs", 32'(op_cnt), 0);
    req_valid = 4'b0000;
    tick();
    check("t1_op_cnt", 32'(op_cnt), 1);
    check("t1_idle_valid", 32'(rsp_valid), 0);
    check("t1_idle_busy", 32'(busy), 0);

    // Parity sequence from requester 2: 111,110,000,100 -> 1,0,0,1
    req_valid = 4'b0100; req_data = 12'b000_111_000_000;
    #1;
    check("par_req_ready", 32'(req_ready), 32'b0100);
    tick();
    check("par_111", 32'(rsp_parity), 1);
    check("par_id", 32'(rsp_id), 2);
    req_data = 12'b000_110_000_000;
    tick();
    check("par_110", 32'(rsp_parity), 0);
    check("par_data_110", 32'(rsp_data), 32'b110);
    req_data = 12'b000_000_000_000;
    tick();
    check("par_000", 32'(rsp_parity), 0);
    req_data = 12'b000_100_000_000;
    tick();
    check("par_100", 32'(rsp_parity), 1);
    check("par_op_cnt", 32'(op_cnt), 4);
    req_valid = 4'b0000;
    tick();
    check("par_end_cnt", 32'(op_cnt), 5);
    check("par_end_valid", 32'(rsp_valid), 0);

    // Reset asserted while a response is held
    req_valid = 4'b0010; req_data = 12'b000_000_011_000; rsp_ready = 1'b0;
    tick();
    check("mr_valid_held", 32'(rsp_valid), 1);
    check("mr_id_held", 32'(rsp_id), 1);
    check("mr_cnt_held", 32'(op_cnt), 5);
    #1;
    rst = 1'b1;
    #1;
    check("mr_async_valid", 32'(rsp_valid), 0);
    check("mr_async_cnt", 32'(op_cnt), 0);
    check("mr_async_id", 32'(rsp_id), 0);
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    check("mr_rst_no_grant", 32'(req_ready), 0);
    tick();
    check("mr_rst_valid_edge", 32'(rsp_valid), 0);
    rst = 1'b0;

    // All requesters valid, rsp_ready=1: one grant per cycle
    req_data = {sl[3], sl[2], sl[1], sl[0]};
    #1;
    for (int i = 0; i < 6; i++) begin
`ifdef RR_ARB_EN
      exp_id = i % 4;
`else
      exp_id = 0;
`endif
      check($sformatf("arb_grant_%0d", i), 32'(req_ready), 32'(1) << exp_id);
      tick();
      check($sformatf("arb_id_%0d", i), 32'(rsp_id), 32'(exp_id));
      check($sformatf("arb_data_%0d", i), 32'(rsp_data), 32'(sl[exp_id]));
      check($sformatf("arb_par_%0d", i), 32'(rsp_parity), 32'(^sl[exp_id]));
    end
    check("arb_op_cnt", 32'(op_cnt), 5);

    // Back-pressure for 5 cycles: outputs hold, no grants
`ifdef RR_ARB_EN
    exp_id = 1; nxt_id = 2;
`else
    exp_id = 0; nxt_id = 0;
`endif
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_ready_%0d", i), 32'(req_ready), 0);
      tick();
      check($sformatf("stall_valid_%0d", i), 32'(rsp_valid), 1);
      check($sformatf("stall_id_%0d", i), 32'(rsp_id), 32'(exp_id));
      check($sformatf("stall_data_%0d", i), 32'(rsp_data), 32'(sl[exp_id]));
      check($sformatf("stall_cnt_%0d", i), 32'(op_cnt), 5);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_grant", 32'(req_ready), 32'(1) << nxt_id);
    tick();
    check("release_id", 32'(rsp_id), 32'(nxt_id));
    check("release_cnt", 32'(op_cnt), 6);

    // op_cnt wrap at CNTW=4: 17 handshakes since reset -> 1
    repeat (9) tick();
    check("wrap_15", 32'(op_cnt), 15);
    tick();
    check("wrap_0", 32'(op_cnt), 0);
    tick();
    check("wrap_1", 32'(op_cnt), 1);

    req_valid = 4'b0000;
    tick();
    check("final_cnt", 32'(op_cnt), 2);
    check("final_valid", 32'(rsp_valid), 0);
    check("final_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_share_arb.md
# parity_share_arb

Arbitrated front end for a shared WIDTH-bit XOR-reduction (parity) unit. It lets NREQ requesters share one combinational parity datapath through valid/ready handshakes. Each accepted operand produces one registered response, tagged with the requester index, on a single output channel. The block sits between parity consumers in the test/verification environment and the shared `xor_reduce` datapath.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..16)
- WIDTH, 3: operand width in bits (1..32)
- CNTW, 16: width of the completed-operation counter

Ports:
- clk  input  1  the single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous and active-high
- req_valid  input  NREQ  per-requester operand valid
- req_data  input  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
- req_ready  output  NREQ  one-hot grant/accept; at most one bit high
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accepted by consumer
- rsp_id  output  $clog2(NREQ)  index of the requester that supplied the operand
- rsp_data  output  WIDTH  captured operand
- rsp_parity  output  1  XOR of all bits of rsp_data (even parity bit)
- op_cnt  output  CNTW  count of completed response handshakes
- busy  output  1  high whenever rsp_valid is high or any req_valid is high

## Operation
- FSM states: IDLE (no response held) and RESP (response held, rsp_valid=1).
- Accept window: `accept = (state==IDLE) | (state==RESP & rsp_ready)`. Outside the window, req_ready is all zero.
- In the accept window with any req_valid set:
  - the arbiter picks a winner w and drives req_ready[w]=1 combinationally in the same cycle;
  - on the clock edge, rsp_data is loaded from the operand slice of w, rsp_id from w, and rsp_parity from the parity of that slice;
  - state becomes RESP and the round-robin pointer becomes w.
- In RESP with rsp_ready=1 and no req_valid: state becomes IDLE and rsp_valid drops.
- In RESP with rsp_ready=0: all rsp_* outputs are held stable and no request is accepted.
- Response handshake (rsp_valid & rsp_ready): op_cnt increments by 1 and wraps from 2^CNTW-1 to 0.
- Arbitration is round-robin with RR_ARB_EN defined (see Configuration). The search starts at pointer+1, modulo NREQ.
- Requesters must hold req_valid and req_data stable until they are granted. A requester that drops req_valid before being granted is simply skipped.
- Parity is computed only by the `xor_reduce` sub-module, which is pure combinational logic.

## Timing
- Latency: operand accepted at edge n; rsp_valid is high after edge n and the response is visible in cycle n+1.
- Throughput: one operation per cycle when rsp_ready is held high and requests are continuous.
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_parity=0;
  - op_cnt=0, state=IDLE;
  - round-robin pointer=NREQ-1, so requester 0 wins first.
- req_ready and busy are combinational from state, the pointer, req_valid and rsp_ready.
- Reset asserted mid-operation: rsp_valid clears immediately, without waiting for clk, and any held response is discarded and never counted. With rst high, req_ready stays 0 regardless of req_valid.
- Simultaneous response handshake and new grant in the same cycle: op_cnt counts the old response, and the rsp_* outputs load the new operand.
- NREQ not a power of 2: pointer wrap uses an explicit compare against NREQ-1, never natural overflow.

## Configuration
- RR_ARB_EN defined: round-robin arbitration using the pointer as described above.
- RR_ARB_EN undefined: fixed priority, lowest requester index wins. The pointer register is not implemented, and there is no fairness guarantee.
- All other behaviour is identical in both builds.

## Structure
- Package `parity_arb_pkg`:
  - state enum (IDLE, RESP);
  - localparam helper for the id width;
  - the `xor_reduce` parity function, shared with other parity users.
- Sub-module `xor_reduce`: parameterized WIDTH, purely combinational, output = XOR of all input bits. It is instantiated once, on the muxed winner operand.
- The top level contains the arbiter, the FSM, the response registers and op_cnt.

## Test plan
- Reset, then requester 0 with data 3'b101 and rsp_ready=1 → one cycle later rsp_valid=1, rsp_id=0, rsp_data=101, rsp_parity=0, op_cnt=1.
- All 4 requesters valid, rsp_ready=1, RR_ARB_EN defined → grants in order 0,1,2,3,0,… with one grant per cycle. Undefined build → requester 0 is granted every cycle.
- rsp_ready held 0 for 5 cycles with requests pending → rsp_* stable, req_ready=0; releasing rsp_ready → next grant in that same cycle.
- Operands 3'b111, 3'b110, 3'b000, 3'b100 from requester 2 → rsp_parity values 1, 0, 0, 1 respectively.
- CNTW=4 with 17 handshakes → op_cnt wraps 15→0 and reads 1 at the end.
- rst pulsed while rsp_valid=1 → rsp_valid=0 before the next clk edge, op_cnt=0, and the first grant after reset goes to requester 0.
